// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// condNegate provides both the operand-magnitude step and the final sign fixup.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } divState_t;

    localparam int          DIV_STEPS     = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

    function automatic logic [31:0] condNegate(input logic [31:0] value, input logic negate);
        return negate ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift {rem, quo} left, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_remShift;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH-1:0] w_quoShift;

    // The running remainder stays below the divisor, so its top bit is always zero;
    // carrying one extra bit here keeps the sign of the trial exact.
    assign w_remShift = {i_rem, i_quo[WIDTH-1]};
    assign w_quoShift = {i_quo[WIDTH-2:0], 1'b0};
    assign w_trial    = w_remShift - {2'b00, i_divisor};

    always_comb begin
        o_rem = w_remShift[WIDTH:0];
        o_quo = w_quoShift;
        if (!w_trial[WIDTH+1]) begin
            o_rem = w_trial[WIDTH:0];
            o_quo = {w_quoShift[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned 32-bit divider with a start/done handshake.
// Divides operand magnitudes over 32 restoring steps, then restores the signs.
import div_pkg::*;

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W     = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    divState_t        r_state;
    divState_t        w_stateNext;

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_negQuo;
    logic             r_negRem;
    logic [CNT_W-1:0] r_stepCnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_divByZero;

    logic [WIDTH:0]   w_remNext;
    logic [WIDTH-1:0] w_quoNext;
    logic             w_bZero;
    logic             w_aNeg;
    logic             w_bNeg;

    assign w_bZero = (b == '0);
    assign w_aNeg  = is_signed & a[WIDTH-1];
    assign w_bNeg  = is_signed & b[WIDTH-1];

    div_step #(
        .WIDTH(WIDTH)
    ) u_divStep (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_remNext),
        .o_quo     (w_quoNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = w_bZero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_stepCnt == LAST_STEP) begin
                    w_stateNext = FIX;
                end
            end
            FIX:     w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // busy and done are derived from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_negQuo    <= 1'b0;
            r_negRem    <= 1'b0;
            r_stepCnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divByZero <= 1'b0;
        end else begin
            r_busy <= (w_stateNext != IDLE);
            r_done <= (w_stateNext == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem       <= '0;
                        r_quo       <= condNegate(a, w_aNeg);
                        r_divisor   <= condNegate(b, w_bNeg);
                        r_negQuo    <= w_aNeg ^ w_bNeg;
                        r_negRem    <= w_aNeg;
                        r_stepCnt   <= '0;
                        r_divByZero <= w_bZero;
                        if (w_bZero) begin
                            r_quotient  <= DIV0_QUOTIENT;
                            r_remainder <= a;
                        end
                    end
                end
                RUN: begin
                    r_rem     <= w_remNext;
                    r_quo     <= w_quoNext;
                    r_stepCnt <= r_stepCnt + 1'b1;
                end
                FIX: begin
                    r_quotient  <= condNegate(r_quo, r_negQuo);
                    r_remainder <= condNegate(r_rem[WIDTH-1:0], r_negRem);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_divByZero;

endmodule
